// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage pipeline: load-use stalls, execute-stage
// redirect flushes, dmem wait freezes, saturating perf counters and a sticky timeout flag.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       addr_rs1_d,
  input  logic [4:0]       addr_rs2_d,
  input  logic             rs1_used_d,
  input  logic             rs2_used_d,
  input  logic [4:0]       rd_x,
  input  logic             regwrite_x,
  input  logic             is_load_x,
  input  logic             redirect_x,
  input  logic             dmem_req_m,
  input  logic             dmem_ready_m,
  output logic             stall_fd,
  output logic             kill_fd,
  output logic             bubble_dx,
  output logic             stall_all,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              load_use_s;
  logic              mem_wait_s;

  // x0 is hardwired zero, so a load targeting it can never create a hazard.
  assign load_use_s = is_load_x && regwrite_x && (rd_x != 5'd0) &&
                      ((rs1_used_d && (addr_rs1_d == rd_x)) ||
                       (rs2_used_d && (addr_rs2_d == rd_x)));
  assign mem_wait_s = dmem_req_m && !dmem_ready_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      err_timeout_q <= err_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    err_timeout_d = err_timeout_q;
    case (state_q)
      RUN: begin
        if (mem_wait_s) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end else begin
          state_d    = RUN;
        end
      end
      MEM_WAIT: begin
        // A dropped request is treated the same as a completed one.
        if (!dmem_req_m || dmem_ready_m) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          if (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1)) begin
            err_timeout_d = 1'b1;
          end else begin
            err_timeout_d = err_timeout_q;
          end
          if (wait_cnt_q < WC_W'(MEM_TIMEOUT)) begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
          end else begin
            wait_cnt_d = wait_cnt_q;
          end
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Outputs are forced low while reset is held so nothing leaks out mid-reset.
  always_comb begin
    stall_fd  = 1'b0;
    kill_fd   = 1'b0;
    bubble_dx = 1'b0;
    stall_all = 1'b0;
    if (rst) begin
      stall_fd  = 1'b0;
    end else if (state_q == MEM_WAIT || mem_wait_s) begin
      stall_all = 1'b1;
      stall_fd  = 1'b1;
    end else if (redirect_x) begin
      kill_fd   = 1'b1;
      bubble_dx = 1'b1;
    end else if (load_use_s) begin
      stall_fd  = 1'b1;
      bubble_dx = 1'b1;
    end else begin
      stall_fd  = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((stall_fd || stall_all) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (kill_fd && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  assign err_timeout = err_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It generates the per-cycle stall, flush and bubble controls for the fetch/decode and decode/execute pipeline registers. It resolves load-use hazards, taken branches/jumps resolved in execute, and multi-cycle data-memory waits. It also keeps saturating performance counters and a sticky memory-timeout error flag.

Parameters:
CNT_W, 32, width of stall and flush performance counters
MEM_TIMEOUT, 64, maximum consecutive dmem wait cycles before err_timeout sets (must be >= 2)

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-high reset
addr_rs1_d  in  5  rs1 index of instruction in decode
addr_rs2_d  in  5  rs2 index of instruction in decode
rs1_used_d  in  1  decode instruction reads rs1
rs2_used_d  in  1  decode instruction reads rs2
rd_x  in  5  destination of instruction in execute
regwrite_x  in  1  execute instruction writes rd
is_load_x  in  1  execute instruction is a load
redirect_x  in  1  taken branch or JAL/JALR resolved in execute
dmem_req_m  in  1  memory stage issuing a dmem access
dmem_ready_m  in  1  dmem access completes this cycle
stall_fd  out  1  hold PC and F/D register (drives fetch_decode stall)
kill_fd  out  1  flush F/D to NOP 0x00000013, PC_d=0 (drives fetch_decode kill_dx)
bubble_dx  out  1  load NOP into D/X register
stall_all  out  1  freeze every pipeline register and PC
err_timeout  out  1  sticky: dmem wait exceeded MEM_TIMEOUT
stall_cnt  out  CNT_W  cycles with stall_fd or stall_all high
flush_cnt  out  CNT_W  number of redirect flushes issued

Behaviour:
- Control outputs are combinational from the current state and inputs, so they act in the same cycle. State, counters and err_timeout are registered.
- FSM states: RUN, MEM_WAIT.
- RUN:
  - Memory wait: dmem_req_m & !dmem_ready_m -> stall_all=1, stall_fd=1, kill_fd=0, bubble_dx=0; next state MEM_WAIT, wait_cnt<=1.
  - Otherwise, if redirect_x -> kill_fd=1, bubble_dx=1, stall_fd=0; flush_cnt+1.
  - Otherwise, load-use: is_load_x & regwrite_x & rd_x!=0 & ((rs1_used_d & addr_rs1_d==rd_x) | (rs2_used_d & addr_rs2_d==rd_x)) -> stall_fd=1, bubble_dx=1, exactly one cycle. The load then moves to memory and the hazard clears naturally.
  - Otherwise all controls are 0.
- MEM_WAIT:
  - stall_all=1 and stall_fd=1 every cycle; kill_fd and bubble_dx are forced 0.
  - Because the pipeline is frozen, redirect_x and any load-use condition are re-evaluated in RUN after the wait ends. They are not lost and not double-counted.
  - dmem_ready_m=1 -> stall_all is still 1 in that cycle (completing cycle). Next state RUN, wait_cnt<=0.
  - Each cycle without ready, wait_cnt increments, saturating at MEM_TIMEOUT.
  - When wait_cnt==MEM_TIMEOUT-1 and ready=0, err_timeout<=1 (sticky until rst). The FSM keeps waiting; there is no forced abort.
  - dmem_req_m dropping to 0 while in MEM_WAIT is treated as completion (-> RUN).
- Priority, highest first: memory wait > redirect > load-use. A redirect coinciding with load-use produces the flush only; the decode instruction is wrong-path.
- x0 is never a hazard source.
- Counters:
  - stall_cnt increments on every cycle stall_fd|stall_all is high.
  - flush_cnt increments once per issued redirect flush.
  - Both saturate at all-ones and do not wrap.
- Reset (async, rst high):
  - state=RUN, wait_cnt=0, counters=0, err_timeout=0.
  - All control outputs read 0 while reset is held, regardless of inputs.
  - Reset mid-MEM_WAIT returns the FSM to RUN immediately.

Test Plan:
- Load x5 in X with rs1_used_d=1, addr_rs1_d=5 -> one cycle of stall_fd=1, bubble_dx=1. Next cycle (load in M, no dmem wait) all controls 0; stall_cnt=1.
- Load with rd_x=0 and addr_rs1_d=0 -> no stall. Non-load regwrite_x with matching rd -> no stall.
- redirect_x=1 for one cycle -> kill_fd=1, bubble_dx=1, stall_fd=0; flush_cnt=1. Redirect together with a load-use match -> flush only, stall_cnt unchanged.
- dmem_req_m=1 with ready low 3 cycles, high on the 4th -> stall_all high 4 cycles, FSM back in RUN on cycle 5. A redirect_x held during the wait produces kill_fd only on cycle 5.
- MEM_TIMEOUT=4, ready never asserted -> err_timeout rises after 4 wait cycles and stays 1 after ready later arrives. rst pulse clears it and returns the FSM to RUN asynchronously.
- Force stall_cnt to all-ones (CNT_W=4 build, 16+ stall cycles) -> holds at 4'hF.
